aes_req_arbiter: RTL and testbench

//  Shares one aes_cipher_top instance among N_REQ requesters. Round-robin arbitration

---
 rtl/aes_arb_pkg.sv | 30 +++
 rtl/aes_rr_arb.sv | 29 ++
 rtl/aes_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES request arbiter: FSM state encoding,
// block width and the round-robin pick function.
package aes_arb_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned PTR_W     = 3;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_t;

  // First valid index at or after ptr, wrapping modulo n; zero when nothing is valid.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [PTR_W-1:0]   idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin picker: one-hot grant plus its index, searching
// from rr_ptr_i upward and wrapping.
module aes_rr_arb
  import aes_arb_pkg::*;
#(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid_i;
    pick                   = rr_pick(valid_ext, PTR_W'(rr_ptr_i), N_REQ);
    gnt_o                  = pick[N_REQ-1:0];
    gnt_id_o               = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) gnt_id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core among N_REQ requesters, one block in flight at a time.
// Define AES_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns resp_err=1.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned  N_REQ       = 4,
  parameter int unsigned  TIMEOUT_CYC = 32,
  localparam int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*128-1:0]   req_key,
  input  logic [N_REQ*128-1:0]   req_text,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [AES_BLK_W-1:0]   resp_text,
  output logic                   resp_err,
  output logic                   aes_ld,
  output logic [AES_BLK_W-1:0]   aes_key,
  output logic [AES_BLK_W-1:0]   aes_text_in,
  input  logic                   aes_done,
  input  logic [AES_BLK_W-1:0]   aes_text_out,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AES_BLK_W-1:0]   key_q, key_d;
  logic [AES_BLK_W-1:0]   text_q, text_d;
  logic [ID_W-1:0]        resp_id_q, resp_id_d;
  logic [AES_BLK_W-1:0]   resp_text_q, resp_text_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   aes_ld_q, aes_ld_d;
  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   xfer;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   resp_err_q, resp_err_d;
`else
  logic                   unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  aes_rr_arb #(
    .N_REQ (N_REQ)
  ) u_rr_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id)
  );

  // Gated by rst so the grant is also 0 while reset is held.
  assign req_ready = (state_q == StIdle && rst) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    key_d        = key_q;
    text_d       = text_q;
    resp_id_d    = resp_id_q;
    resp_text_d  = resp_text_q;
    resp_valid_d = resp_valid_q;
    aes_ld_d     = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    tmr_d        = tmr_q;
    resp_err_d   = resp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              key_d  = req_key[i*AES_BLK_W +: AES_BLK_W];
              text_d = req_text[i*AES_BLK_W +: AES_BLK_W];
            end
          end
          resp_id_d = gnt_id;
          rr_ptr_d  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          aes_ld_d  = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        state_d = StWait;
`ifdef AES_ARB_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      StWait: begin
        if (aes_done) begin
          resp_text_d  = aes_text_out;
          resp_valid_d = 1'b1;
          state_d      = StResp;
`ifdef AES_ARB_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          resp_text_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          tmr_d = tmr_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      key_q        <= '0;
      text_q       <= '0;
      resp_id_q    <= '0;
      resp_text_q  <= '0;
      resp_valid_q <= 1'b0;
      aes_ld_q     <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      tmr_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      key_q        <= key_d;
      text_q       <= text_d;
      resp_id_q    <= resp_id_d;
      resp_text_q  <= resp_text_d;
      resp_valid_q <= resp_valid_d;
      aes_ld_q     <= aes_ld_d;
`ifdef AES_ARB_TIMEOUT_EN
      tmr_q        <= tmr_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_text   = resp_text_q;
  assign aes_ld      = aes_ld_q;
  assign aes_key     = key_q;
  assign aes_text_in = text_q;
  assign busy        = (state_q != StIdle);
`ifdef AES_ARB_TIMEOUT_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter with a behavioural stub core driven
// from the stimulus tasks and a transaction-level round-robin reference model.
module tb_aes_req_arbiter;

  localparam int unsigned NR = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*128-1:0] req_key, req_text;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [127:0]      resp_text;
  logic              resp_err, aes_ld;
  logic [127:0]      aes_key, aes_text_in;
  logic              aes_done;
  logic [127:0]      aes_text_out;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  aes_req_arbiter #(
    .N_REQ       (NR),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_text     (req_text),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_text    (resp_text),
    .resp_err     (resp_err),
    .aes_ld       (aes_ld),
    .aes_key      (aes_key),
    .aes_text_in  (aes_text_in),
    .aes_done     (aes_done),
    .aes_text_out (aes_text_out),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub core transform: the known FIPS-197 vector, otherwise a cheap keyed mix.
  function automatic logic [127:0] cipher_ref(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'hc3a5_0f1e_7788_9911_2244_6b5d_e0f1_3c2a;
  endfunction

  // Reference round-robin rule: first requester at or after ptr, wrapping.
  function automatic int exp_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic rand_reqs();
    for (int i = 0; i < NR; i++) begin
      req_key[i*128 +: 128]  = rand128();
      req_text[i*128 +: 128] = rand128();
    end
  endtask

  // One full block starting in an IDLE cycle (called just after a negedge).
  task automatic run_txn(input logic [NR-1:0] vld, input int lat, input int rdly,
                         input bit spurious, output int gid);
    logic [NR-1:0] eg;
    logic [127:0]  k, t, ct;
    gid = exp_pick(vld, exp_ptr);
    eg  = '0;
    eg[gid] = 1'b1;
    req_valid = vld;
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("grant", req_ready, eg);
    k  = req_key[gid*128 +: 128];
    t  = req_text[gid*128 +: 128];
    ct = cipher_ref(k, t);
    @(negedge clk);
    check_eq("load_pulse", aes_ld, 1);
    check_eq("load_ready", req_ready, 0);
    check_eq("load_key", aes_key, k);
    check_eq("load_text", aes_text_in, t);
    if (spurious) begin
      aes_done     = 1'b1;
      aes_text_out = rand128();
    end
    @(negedge clk);
    aes_done = 1'b0;
    check_eq("ld_single", aes_ld, 0);
    for (int i = 1; i < lat; i++) begin
      check_eq("wait_valid", resp_valid, 0);
      @(negedge clk);
    end
    check_eq("wait_ready", req_ready, 0);
    aes_done     = 1'b1;
    aes_text_out = ct;
    @(negedge clk);
    aes_done     = 1'b0;
    aes_text_out = rand128();
    exp_ptr = (gid + 1) % NR;
    for (int i = 0; i <= rdly; i++) begin
      check_eq("resp_valid", resp_valid, 1);
      check_eq("resp_id", resp_id, gid);
      check_eq("resp_text", resp_text, ct);
      check_eq("resp_err", resp_err, 0);
      check_eq("resp_ready_hold", req_ready, 0);
      check_eq("resp_no_ld", aes_ld, 0);
      if (spurious) begin
        aes_done     = 1'b1;
        aes_text_out = rand128();
      end
      if (i == rdly) resp_ready = 1'b1;
      @(negedge clk);
      aes_done = 1'b0;
    end
    resp_ready = 1'b0;
    check_eq("post_valid", resp_valid, 0);
    check_eq("post_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [NR-1:0] v;
    rst          = 1'b0;
    req_valid    = '0;
    resp_ready   = 1'b0;
    aes_done     = 1'b0;
    aes_text_out = '0;
    rand_reqs();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", resp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ld", aes_ld, 0);
    check_eq("rst_key", aes_key, 0);
    check_eq("rst_text", resp_text, 0);
    check_eq("rst_id", resp_id, 0);
    rst = 1'b1;
    @(negedge clk);

    // Fairness: everybody requesting, order must rotate from index 0.
    for (int i = 0; i < 5; i++) begin
      rand_reqs();
      run_txn(4'hf, 1 + $urandom_range(4), 0, 1'b0, g);
      check_eq("fair_order", g, i % NR);
    end

    // Known-answer block from requester 0.
    rand_reqs();
    req_key[0 +: 128]  = FIPS_KEY;
    req_text[0 +: 128] = FIPS_PT;
    run_txn(4'b0001, 10, 0, 1'b0, g);

    // Backpressure with spurious done pulses, then req1 waiting through RESP.
    rand_reqs();
    run_txn(4'b1010, 3, 20, 1'b1, g);
    run_txn(4'b0011, 2, 1, 1'b0, g);
    run_txn(4'b0010, 2, 0, 1'b0, g);

    for (int i = 0; i < 40; i++) begin
      rand_reqs();
      v = NR'($urandom_range(1, 15));
      run_txn(v, 1 + $urandom_range(11), $urandom_range(4), 1'($urandom_range(1)), g);
    end

    // Reset while waiting on the core.
    req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", resp_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    check_eq("mid_rst_ld", aes_ld, 0);
    check_eq("mid_rst_key", aes_key, 0);
    check_eq("mid_rst_text_in", aes_text_in, 0);
    check_eq("mid_rst_id", resp_id, 0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    exp_ptr   = 0;
    aes_done  = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("post_rst_valid", resp_valid, 0);
      @(negedge clk);
    end
    rand_reqs();
    run_txn(4'hf, 2, 0, 1'b0, g);

    // Core that never answers.
    rand_reqs();
    req_valid = 4'b0010;
    g = exp_pick(4'b0010, exp_ptr);
    @(negedge clk);
    req_valid = '0;
    check_eq("to_load", aes_ld, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_eq("to_wait_valid", resp_valid, 0);
    end
    @(negedge clk);
`ifdef AES_ARB_TIMEOUT_EN
    check_eq("to_valid", resp_valid, 1);
    check_eq("to_err", resp_err, 1);
    check_eq("to_text", resp_text, 0);
    check_eq("to_id", resp_id, g);
`else
    for (int i = 0; i < 8; i++) begin
      check_eq("no_to_valid", resp_valid, 0);
      check_eq("no_to_busy", busy, 1);
      check_eq("no_to_err", resp_err, 0);
      @(negedge clk);
    end
    aes_done     = 1'b1;
    aes_text_out = cipher_ref(req_key[g*128 +: 128], req_text[g*128 +: 128]);
    @(negedge clk);
    aes_done = 1'b0;
    check_eq("late_valid", resp_valid, 1);
    check_eq("late_text", resp_text,
             cipher_ref(req_key[g*128 +: 128], req_text[g*128 +: 128]));
`endif
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_ptr = (g + 1) % NR;
    check_eq("to_done", resp_valid, 0);
    rand_reqs();
    run_txn(4'b0011, 1, 0, 1'b0, g);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
